// File: rtl/scrambler_64b66b.sv
// Self-synchronous 64b/66b transmit scrambler, G(x) = 1 + x^39 + x^58.
// Scrambles the payload, forwards the sync header unchanged, and flags/counts illegal headers.
module scrambler_64b66b #(
    parameter logic [57:0] SEED_INIT = 58'h3FF_FFFF_FFFF_FFFF,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 enable_scrambler,
    input  logic [65:0]          encoded_data,
    input  logic                 seed_load,
    input  logic [57:0]          seed,
    input  logic                 bypass,
    output logic [65:0]          scrambled_data,
    output logic                 tx_valid,
    output logic                 hdr_err,
    output logic [CNT_WIDTH-1:0] hdr_err_count
);

    localparam int unsigned PAY_W   = 64;
    localparam int unsigned STATE_W = 58;

    logic [STATE_W-1:0]   r_state;
    logic [65:0]          r_data;
    logic                 r_tx_valid;
    logic                 r_hdr_err;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic [STATE_W-1:0]   w_state_next;
    logic [PAY_W-1:0]     w_scrambled;
    logic                 w_hdr_bad;

    // All 64 serial scrambler steps unrolled; S[0] always holds the newest output bit.
    always_comb begin
        w_state_next = r_state;
        w_scrambled  = '0;
        for (int k = 0; k < 64; k++) begin
            w_scrambled[k] = encoded_data[2+k] ^ w_state_next[38] ^ w_state_next[57];
            w_state_next   = {w_state_next[56:0], w_scrambled[k]};
        end
    end

    assign w_hdr_bad = (encoded_data[1] == encoded_data[0]);

    // Seed load wins over a same-cycle block; bypass freezes the state but keeps header checking.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= SEED_INIT;
            r_data     <= '0;
            r_tx_valid <= 1'b0;
            r_hdr_err  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_tx_valid <= 1'b0;
            r_hdr_err  <= 1'b0;
            if (seed_load) begin
                r_state <= seed;
            end else if (enable_scrambler) begin
                r_tx_valid <= 1'b1;
                r_hdr_err  <= w_hdr_bad;
                if (bypass) begin
                    r_data <= encoded_data;
                end else begin
                    r_data  <= {w_scrambled, encoded_data[1:0]};
                    r_state <= w_state_next;
                end
                if (w_hdr_bad && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign scrambled_data = r_data;
    assign tx_valid       = r_tx_valid;
    assign hdr_err        = r_hdr_err;
    assign hdr_err_count  = r_cnt;

endmodule

// File: tb/tb_scrambler_64b66b.sv
// Bench for scrambler_64b66b: directed vector table, saturation sequence, random stream against a bit-serial model.
module tb_scrambler_64b66b;

    localparam logic [57:0] SEED_INIT = 58'h3FF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sl;
    logic        byp;
    logic [65:0] din;
    logic [57:0] seed;

    logic [65:0] data_a;
    logic        valid_a;
    logic        err_a;
    logic [15:0] cnt_a;
    logic [65:0] data_b;
    logic        valid_b;
    logic        err_b;
    logic [1:0]  cnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    scrambler_64b66b #(.SEED_INIT(SEED_INIT), .CNT_WIDTH(16)) dut_a (
        .CLK(clk), .RST(rst), .enable_scrambler(en), .encoded_data(din),
        .seed_load(sl), .seed(seed), .bypass(byp),
        .scrambled_data(data_a), .tx_valid(valid_a), .hdr_err(err_a), .hdr_err_count(cnt_a)
    );

    scrambler_64b66b #(.SEED_INIT(SEED_INIT), .CNT_WIDTH(2)) dut_b (
        .CLK(clk), .RST(rst), .enable_scrambler(en), .encoded_data(din),
        .seed_load(sl), .seed(seed), .bypass(byp),
        .scrambled_data(data_b), .tx_valid(valid_b), .hdr_err(err_b), .hdr_err_count(cnt_b)
    );

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: history of transmitted bits, oldest first; newest bit is the last entry.
    bit          m_hist[$];
    logic [65:0] m_data;
    logic        m_valid;
    logic        m_err;
    int          m_cnt;
    int          m_cnt2;

    function automatic void model_seed(input logic [57:0] s);
        m_hist.delete();
        for (int i = 0; i < 58; i++) m_hist.push_back(s[57-i]);
    endfunction

    // Each output bit is the input bit XOR the bits sent 39 and 58 positions earlier.
    function automatic logic [63:0] model_block(input logic [63:0] d);
        logic [63:0] o;
        bit          b;
        for (int k = 0; k < 64; k++) begin
            b = d[k] ^ m_hist[m_hist.size()-39] ^ m_hist[m_hist.size()-58];
            o[k] = b;
            m_hist.push_back(b);
            void'(m_hist.pop_front());
        end
        return o;
    endfunction

    task automatic chk_all(input string tag);
        chk({tag, ".valid"}, 66'(valid_a), 66'(m_valid));
        chk({tag, ".data"},  data_a, m_data);
        chk({tag, ".err"},   66'(err_a), 66'(m_err));
        chk({tag, ".cnt"},   66'(cnt_a), 66'(m_cnt));
        chk({tag, ".cnt2"},  66'(cnt_b), 66'(m_cnt2));
    endtask

    task automatic rand_step(input bit force_sl);
        logic [63:0] pay;
        logic [1:0]  hdr;
        logic        bad;
        en   = ($urandom_range(3) != 0);
        sl   = force_sl || ($urandom_range(31) == 0);
        byp  = ($urandom_range(7) == 0);
        seed = 58'({$urandom(), $urandom()});
        pay  = {$urandom(), $urandom()};
        hdr  = 2'($urandom_range(3));
        din  = {pay, hdr};
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (sl) begin
            model_seed(seed);
        end else if (en) begin
            bad     = (hdr == 2'b00) || (hdr == 2'b11);
            m_valid = 1'b1;
            m_err   = bad;
            m_data  = byp ? din : {model_block(pay), hdr};
            if (bad) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        chk_all("rand");
    endtask

    typedef struct {
        logic        en;
        logic        sl;
        logic        byp;
        logic [1:0]  hdr;
        logic [63:0] pay;
        logic        exp_valid;
        logic [65:0] exp_data;
        logic        exp_err;
        int          exp_cnt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        rst = 1'b1; en = 1'b0; sl = 1'b0; byp = 1'b0; din = '0; seed = '0;

        // Seed-0 results: an input 1 at bit 0 echoes at bits 39 and 58 via the two taps.
        tbl[0] = '{1'b0, 1'b1, 1'b0, 2'b10, 64'h0,                  1'b0, 66'h0,                                1'b0, 0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 2'b10, 64'hDEAD_BEEF_0123_4567, 1'b1, {64'hDEAD_BEEF_0123_4567, 2'b10}, 1'b0, 0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 2'b11, 64'h0123_4567_89AB_CDEF, 1'b1, {64'h0123_4567_89AB_CDEF, 2'b11}, 1'b1, 1};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, {64'hFFFF_FFFF_FFFF_FFFF, 2'b00}, 1'b1, 2};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 2'b01, 64'h0,                  1'b1, {64'h0, 2'b01},                    1'b0, 2};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 2'b11, 64'h1234,               1'b0, {64'h0, 2'b01},                    1'b0, 2};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 2'b10, 64'h1,                  1'b1, {64'h0400_0080_0000_0001, 2'b10}, 1'b0, 2};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 2'b10, 64'h0,                  1'b1, {64'h0030_0000_0000_4000, 2'b10}, 1'b0, 2};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 2'b11, 64'h5555_5555_5555_5555, 1'b0, {64'h0030_0000_0000_4000, 2'b10}, 1'b0, 2};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 2'b01, 64'h1,                  1'b1, {64'h0400_0080_0000_0001, 2'b01}, 1'b0, 2};

        repeat (2) @(posedge clk);
        #1;
        chk("reset.valid", 66'(valid_a), 66'(0));
        chk("reset.data",  data_a, 66'h0);
        chk("reset.err",   66'(err_a), 66'(0));
        chk("reset.cnt",   66'(cnt_a), 66'(0));
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            en = tbl[i].en; sl = tbl[i].sl; byp = tbl[i].byp;
            din = {tbl[i].pay, tbl[i].hdr}; seed = '0;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.valid", i), 66'(valid_a), 66'(tbl[i].exp_valid));
            chk($sformatf("vec%0d.data", i),  data_a, tbl[i].exp_data);
            chk($sformatf("vec%0d.err", i),   66'(err_a), 66'(tbl[i].exp_err));
            chk($sformatf("vec%0d.cnt", i),   66'(cnt_a), 66'(tbl[i].exp_cnt));
            chk($sformatf("vec%0d.cnt2", i),  66'(cnt_b),
                66'((tbl[i].exp_cnt > 3) ? 3 : tbl[i].exp_cnt));
        end

        // Five more illegal headers: the 2-bit counter pins at 3 while the 16-bit one keeps going.
        for (int i = 0; i < 5; i++) begin
            en = 1'b1; sl = 1'b0; byp = 1'b1;
            din = {64'(i * 17 + 3), (i % 2 == 0) ? 2'b11 : 2'b00};
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d.err", i),  66'(err_a), 66'(1));
            chk($sformatf("sat%0d.cnt", i),  66'(cnt_a), 66'(3 + i));
            chk($sformatf("sat%0d.cnt2", i), 66'(cnt_b), 66'(3));
            chk($sformatf("sat%0d.data", i), data_a, din);
            m_data = din;
        end

        m_cnt = 7; m_cnt2 = 3;
        rand_step(1'b1);
        for (int i = 0; i < 300; i++) rand_step(1'b0);

        // Reset mid-stream with a live block on the input.
        rst = 1'b1; en = 1'b1; sl = 1'b0; byp = 1'b0; din = {64'hCAFE_F00D_1234_5678, 2'b11};
        @(posedge clk);
        #1;
        chk("midrst.valid", 66'(valid_a), 66'(0));
        chk("midrst.data",  data_a, 66'h0);
        chk("midrst.err",   66'(err_a), 66'(0));
        chk("midrst.cnt",   66'(cnt_a), 66'(0));
        rst = 1'b0;
        m_data = '0; m_cnt = 0; m_cnt2 = 0; m_valid = 1'b0; m_err = 1'b0;
        model_seed(SEED_INIT);

        en = 1'b1; sl = 1'b0; byp = 1'b0; din = {64'h0123_4567_89AB_CDEF, 2'b10};
        @(posedge clk);
        #1;
        m_valid = 1'b1;
        m_data  = {model_block(64'h0123_4567_89AB_CDEF), 2'b10};
        chk_all("postrst");
        for (int i = 0; i < 60; i++) rand_step(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
